// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared definitions for the user-key debouncer: FSM state
//                encoding and a millisecond-to-cycle conversion helper that
//                other timed blocks reuse.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    // Debouncer FSM state encoding
    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        PRESS_FILTER   = 2'd1,
        PRESSED        = 2'd2,
        RELEASE_FILTER = 2'd3
    } key_state_t;

    // Converts a duration in ms to a clock-cycle count (integer arithmetic,
    // the division comes first so large clock rates do not overflow)
    function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                                 input int unsigned ms);
        return (clk_freq / 1000) * ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Generic two-flop synchronizer for signals asynchronous to
//                clk. Both stages reset to RESET_VAL so the output does not
//                show a spurious transition when reset is released.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; the first may go metastable, the second settles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Debounces one active-low push button. Synchronizes the raw
//                pin, filters bounce with a four-state FSM and emits
//                registered single-cycle press / release / long-press pulses
//                plus a registered debounced level (1 = pressed).
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import key_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned DB_CYCLES   = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYCLES = ms_to_cycles(CLK_FREQ, LONG_MS);
    localparam int          DB_W        = $clog2(DB_CYCLES);
    localparam int          LONG_W      = $clog2(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    // Both windows need at least two cycles: the counters would have zero
    // width otherwise, and press/long could coincide
    if (DB_CYCLES < 2) begin : g_db_check
        $error("key_debounce: debounce window must be at least 2 cycles");
    end
    if (LONG_CYCLES < 2) begin : g_long_check
        $error("key_debounce: long-press window must be at least 2 cycles");
    end

    logic              key_s;
    key_state_t        state;
    key_state_t        state_next;
    logic [DB_W-1:0]   db_cnt;
    logic [DB_W-1:0]   db_cnt_next;
    logic [LONG_W-1:0] long_cnt;
    logic [LONG_W-1:0] long_cnt_next;
    logic              long_fired;
    logic              long_fired_next;
    logic              press_next;
    logic              release_next;
    logic              long_next;
    logic              level_next;

    // Raw pin into the clock domain; idles at 1 (released)
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_in),
        .q     (key_s)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            db_cnt      <= '0;
            long_cnt    <= '0;
            long_fired  <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            state       <= state_next;
            db_cnt      <= db_cnt_next;
            long_cnt    <= long_cnt_next;
            long_fired  <= long_fired_next;
            key_level   <= level_next;
            key_press   <= press_next;
            key_release <= release_next;
            key_long    <= long_next;
        end
    end

    // Next-state, counter updates and output pulses
    always_comb begin
        state_next      = state;
        db_cnt_next     = db_cnt;
        long_cnt_next   = long_cnt;
        long_fired_next = long_fired;
        press_next      = 1'b0;
        release_next    = 1'b0;
        long_next       = 1'b0;

        unique case (state)
            IDLE: begin
                if (!key_s) begin
                    state_next  = PRESS_FILTER;
                    db_cnt_next = '0;
                end
            end

            PRESS_FILTER: begin
                if (key_s) begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_next      = PRESSED;
                    press_next      = 1'b1;
                    long_cnt_next   = '0;
                    long_fired_next = 1'b0;
                end else begin
                    db_cnt_next = db_cnt + DB_W'(1);
                end
            end

            PRESSED: begin
                if (key_s) begin
                    state_next  = RELEASE_FILTER;
                    db_cnt_next = '0;
                end else if (long_cnt != LONG_LAST) begin
                    long_cnt_next = long_cnt + LONG_W'(1);
                end else if (!long_fired) begin
                    // Saturated hold counter: fire once per press
                    long_next       = 1'b1;
                    long_fired_next = 1'b1;
                end
            end

            RELEASE_FILTER: begin
                // long_cnt is frozen here and kept if the release was bounce
                if (!key_s) begin
                    state_next = PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                end else begin
                    db_cnt_next = db_cnt + DB_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        level_next = (state_next == PRESSED) || (state_next == RELEASE_FILTER);
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debounce
//  Description : Self-checking bench for key_debounce with CLK_FREQ=10_000,
//                DEBOUNCE_MS=2, LONG_MS=10 (20-cycle debounce, 100-cycle
//                long press). Stimulus is a table of constant-level segments
//                with the cycle of each expected event inside the segment.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

    localparam int NV = 1_000_000;   // "never" marker for event offsets

    logic clk;
    logic rst_n;
    logic key_in;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_long;

    int checks = 0;
    int errors = 0;

    // One segment: key_in held at 'key' for 'len' edges. Offsets count edges
    // from the first edge that samples the new level (j = 0).
    typedef struct {
        logic key;
        int   len;
        int   press_at;
        int   release_at;
        int   long_at;
        int   lvl_on;
        int   lvl_off;
        int   id;
    } seg_t;

    seg_t segs[$];

    key_debounce #(
        .CLK_FREQ    (10_000),
        .DEBOUNCE_MS (2),
        .LONG_MS     (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic act, input logic exp, input string nm,
                         input int id, input int j);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s seg=%0d cyc=%0d actual=%b expected=%b",
                     nm, id, j, act, exp);
        end
    endtask

    // Called at a negedge; drives the level, checks after every edge
    task automatic run_seg(input seg_t s);
        for (int j = 0; j < s.len; j++) begin
            key_in = s.key;
            @(posedge clk);
            @(negedge clk);
            check(key_press,   1'(j == s.press_at),   "press",   s.id, j);
            check(key_release, 1'(j == s.release_at), "release", s.id, j);
            check(key_long,    1'(j == s.long_at),    "long",    s.id, j);
            check(key_level,   1'((j >= s.lvl_on) && (j < s.lvl_off)),
                  "level", s.id, j);
        end
    endtask

    task automatic check_all_zero(input int id, input int j);
        check(key_press,   1'b0, "rst_press",   id, j);
        check(key_release, 1'b0, "rst_release", id, j);
        check(key_long,    1'b0, "rst_long",    id, j);
        check(key_level,   1'b0, "rst_level",   id, j);
    endtask

    initial begin
        // key, len, press, release, long, lvl_on, lvl_off, id
        // Clean press held 200 cycles: press at 22, long 100 later, release 22
        segs.push_back('{1'b0, 200, 22, NV, 122, 22, NV, 1});
        segs.push_back('{1'b1,  40, NV, 22,  NV,  0, 22, 2});
        // Press bounce: 5 low, 3 high, 8 low, 2 high, then stable low
        segs.push_back('{1'b0,   5, NV, NV,  NV, NV, NV, 3});
        segs.push_back('{1'b1,   3, NV, NV,  NV, NV, NV, 4});
        segs.push_back('{1'b0,   8, NV, NV,  NV, NV, NV, 5});
        segs.push_back('{1'b1,   2, NV, NV,  NV, NV, NV, 6});
        segs.push_back('{1'b0,  50, 22, NV,  NV, 22, NV, 7});
        segs.push_back('{1'b1,  40, NV, 22,  NV,  0, 22, 8});
        // Release bounce after 60 held cycles: the FSM counts 62 hold cycles,
        // leaves PRESSED for 4, then needs 38 more hold edges -> edge 127
        // overall, i.e. offset 40 of the segment starting at edge 87
        segs.push_back('{1'b0,  83, 22, NV,  NV, 22, NV, 9});
        segs.push_back('{1'b1,   4, NV, NV,  NV,  0, NV, 10});
        segs.push_back('{1'b0, 100, NV, NV,  40,  0, NV, 11});
        segs.push_back('{1'b1,  40, NV, 22,  NV,  0, 22, 12});
        // Short tap of 15 cycles: nothing
        segs.push_back('{1'b0,  15, NV, NV,  NV, NV, NV, 13});
        segs.push_back('{1'b1,  30, NV, NV,  NV, NV, NV, 14});

        // Reset state
        rst_n  = 1'b0;
        key_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero(0, 0);
        rst_n = 1'b1;
        run_seg('{1'b1, 5, NV, NV, NV, NV, NV, 0});

        foreach (segs[i]) run_seg(segs[i]);

        // Reset while pressed, 30 cycles after key_press (edge 52)
        run_seg('{1'b0, 53, 22, NV, NV, 22, NV, 15});
        rst_n = 1'b0;
        #1;
        check_all_zero(15, 53);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            @(negedge clk);
            check_all_zero(15, 54 + j);
        end
        rst_n = 1'b1;
        // Key still held: a full new debounce before key_press
        run_seg('{1'b0, 40, 22, NV, NV, 22, NV, 16});
        run_seg('{1'b1, 40, NV, 22, NV,  0, 22, 17});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
